// File: rtl/data_sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_bridge_pkg
//   Shared definitions for the MEM-stage data port bridge: the access state
//   encoding and the bus size codes that travel unchanged from the MEM stage
//   to the sram-like data interface.
// -----------------------------------------------------------------------------
package data_sram_bridge_pkg;

  // Access sequencer states. At most one bus access is outstanding.
  //   IDLE : no access in flight, MEM stage may present a new one
  //   REQ  : data_req high, waiting for the slave to accept the address
  //   WAIT : address accepted, waiting for data_ok
  //   DONE : access finished, result held until MEM stage advances
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bus size codes, identical on the MEM side and on the data bus.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage : data_sram_bridge_pkg

// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
//   Turns the CPU's MEM-stage load/store into one sram-like transaction
//   (req / addr_ok / data_ok) on the data port. While the access is in flight
//   the bridge asks the hazard unit to freeze the pipeline; once the data
//   returns it holds the load result until the MEM stage moves on.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   mem_en_i            MEM stage holds a valid, non-excepting load/store
//   mem_wr_i            1 = store, 0 = load
//   mem_size_i          0 byte, 1 halfword, 2 word
//   mem_addr_i          byte address (already alignment-checked)
//   mem_wdata_i         store data (already lane-shifted)
//   pipe_stall_i        MEM stage frozen by some other cause
//   flush_i             exception flush of the MEM stage
//   mem_rdata_o         load data, valid while the access sits in DONE
//   stall_req_o         freeze request to the hazard unit (combinational)
//   data_req_o ..       registered bus request fields
//   data_wdata_o
//   data_addr_ok_i      slave accepted the request
//   data_data_ok_i      slave returned read data / completed the write
//   data_rdata_i        slave read data
// -----------------------------------------------------------------------------
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  // MEM stage side
  input  logic              mem_en_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              pipe_stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stall_req_o,

  // sram-like data bus side
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  // ---------------------------------------------------------------------------
  // State and next-state
  // ---------------------------------------------------------------------------
  state_e              state_q,  state_d;
  logic                cancel_q, cancel_d;   // access in flight was flushed
  logic                req_q,    req_d;
  logic                wr_q,     wr_d;
  logic [1:0]          size_q,   size_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;

  logic                stall_s;

  // Next-state, bus-field and stall decode for the access sequencer
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    req_d    = req_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    stall_s  = 1'b0;

    case (state_q)
      IDLE: begin
        // A flushed instruction must never reach the bus.
        if (mem_en_i && !flush_i) begin
          stall_s = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          wr_d    = mem_wr_i;
          size_d  = mem_size_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
        end else begin
          stall_s = 1'b0;
          state_d = IDLE;
        end
      end

      REQ: begin
        // The request cannot be withdrawn once raised; a flush only marks
        // the access so that its result is dropped later.
        stall_s = 1'b1;
        if (flush_i) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
        if (data_addr_ok_i) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end

      WAIT: begin
        // Stall stays high even for a cancelled access so the exception
        // handler's first access cannot overlap the one still on the bus.
        stall_s = 1'b1;
        if (data_data_ok_i) begin
          cancel_d = 1'b0;
          if (cancel_q || flush_i) begin
            // Flushed access: discard the data and skip DONE.
            state_d = IDLE;
          end else begin
            state_d = DONE;
            if (!wr_q) begin
              rdata_d = data_rdata_i;
            end else begin
              rdata_d = rdata_q;
            end
          end
        end else begin
          state_d = WAIT;
          if (flush_i) begin
            cancel_d = 1'b1;
          end else begin
            cancel_d = cancel_q;
          end
        end
      end

      DONE: begin
        // The instruction leaves MEM on any edge where it is not frozen,
        // or is removed by a flush; either way no new request is raised here.
        stall_s = 1'b0;
        if (flush_i || !pipe_stall_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        stall_s  = 1'b0;
        state_d  = IDLE;
        cancel_d = 1'b0;
        req_d    = 1'b0;
      end
    endcase
  end

  // Sequencer state, bus fields and load-data holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Bus fields come straight from registers; the stall request is
  // combinational so the hazard unit can freeze the pipeline in the very
  // cycle the access is first seen. It is forced low during reset because
  // the IDLE decode would otherwise follow mem_en_i.
  // ---------------------------------------------------------------------------
  assign stall_req_o  = stall_s & ~rst;
  assign mem_rdata_o  = rdata_q;
  assign data_req_o   = req_q;
  assign data_wr_o    = wr_q;
  assign data_size_o  = size_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;

endmodule : data_sram_bridge

// File: tb/tb_data_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_sram_bridge
//   Drives MEM-stage accesses (directed and random) against a bus slave model
//   with programmable addr_ok / data_ok delays. Expected bus requests and
//   expected mem_rdata values are queued at issue time; a negedge monitor pops
//   and compares them whenever the DUT presents a request or sits in DONE.
// -----------------------------------------------------------------------------
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en, mem_wr, pipe_stall, flush;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_req, data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          addr_ok = 1'b0, data_ok = 1'b0;
  logic [DW-1:0] rdata = '0;

  typedef struct packed {
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  bus_t          req_q[$];      // expected bus requests, in issue order
  logic [DW-1:0] rd_q[$];       // expected mem_rdata per completed access
  bus_t          cur;
  bit            prev_req = 1'b0;
  logic [DW-1:0] model_rdata;   // last load value the MEM stage should see

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration for the access currently in flight
  int            cfg_a_dly = 0;
  int            cfg_d_dly = 0;
  logic [DW-1:0] cfg_rdata = '0;
  bit            spurious_en = 1'b0;
  int            s_ph = 0;
  int            s_cnt = 0;

  data_sram_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_en_i       (mem_en),
    .mem_wr_i       (mem_wr),
    .mem_size_i     (mem_size),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .pipe_stall_i   (pipe_stall),
    .flush_i        (flush),
    .mem_rdata_o    (mem_rdata),
    .stall_req_o    (stall_req),
    .data_req_o     (data_req),
    .data_wr_o      (data_wr),
    .data_size_o    (data_size),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_addr_ok_i (addr_ok),
    .data_data_ok_i (data_ok),
    .data_rdata_i   (rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_data_req"},   32'(data_req),   32'd0);
    chk({tag, "_data_wr"},    32'(data_wr),    32'd0);
    chk({tag, "_data_size"},  32'(data_size),  32'd0);
    chk({tag, "_data_addr"},  data_addr,       32'd0);
    chk({tag, "_data_wdata"}, data_wdata,      32'd0);
    chk({tag, "_mem_rdata"},  mem_rdata,       32'd0);
    chk({tag, "_stall_req"},  32'(stall_req),  32'd0);
  endtask

  // Bus slave: accepts after cfg_a_dly cycles, answers cfg_d_dly cycles later
  always begin
    @(posedge clk);
    #2;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    if (rst) begin
      s_ph = 0;
    end else begin
      if (s_ph == 0 && data_req) begin
        s_ph  = 1;
        s_cnt = cfg_a_dly;
      end
      if (s_ph == 1) begin
        if (s_cnt == 0) begin
          addr_ok = 1'b1;
          s_ph    = 2;
          s_cnt   = cfg_d_dly;
        end else begin
          s_cnt--;
        end
      end else if (s_ph == 2) begin
        if (s_cnt == 0) begin
          data_ok = 1'b1;
          rdata   = cfg_rdata;
          s_ph    = 0;
        end else begin
          s_cnt--;
        end
      end else if (spurious_en && $urandom_range(3, 0) == 0) begin
        // stray data_ok outside WAIT must be ignored by the bridge
        data_ok = 1'b1;
        rdata   = $urandom;
      end
    end
  end

  // Monitor: compare bus requests and DONE-cycle load data with the queues
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (data_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_req: addr %0h with no access pending", data_addr);
          end else begin
            cur = req_q.pop_front();
          end
        end
        chk("req_wr",    32'(data_wr),   32'(cur.wr));
        chk("req_size",  32'(data_size), 32'(cur.size));
        chk("req_addr",  data_addr,      cur.addr);
        chk("req_wdata", data_wdata,     cur.wdata);
      end
      prev_req = data_req;
      // MEM holds an unflushed access yet no stall: the bridge is in DONE
      if (mem_en && !flush && !stall_req) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: mem_rdata %0h with nothing expected", mem_rdata);
        end else begin
          chk("mem_rdata", mem_rdata, rd_q[0]);
          if (!pipe_stall) void'(rd_q.pop_front());
        end
      end
    end
  end

  // One MEM-stage access. fl: 0 normal, 1 flush in first WAIT cycle,
  // 2 flush while held in DONE. Called and returns at posedge+1.
  task automatic access(input logic wr, input logic [1:0] sz, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int ad, input int dd,
                        input logic [DW-1:0] rd, input int ps, input int fl);
    bus_t e;
    int   stall_n = 0, req_n = 0, cyc = 0, k = 0;
    bit   fin = 1'b0;
    cfg_a_dly = ad;
    cfg_d_dly = dd;
    cfg_rdata = rd;
    e.wr = wr; e.size = sz; e.addr = a; e.wdata = wd;
    req_q.push_back(e);
    if (fl != 1) begin
      if (!wr) model_rdata = rd;
      rd_q.push_back(model_rdata);
    end
    mem_en = 1'b1; mem_wr = wr; mem_size = sz; mem_addr = a; mem_wdata = wd;
    flush = 1'b0;
    pipe_stall = (fl == 2) ? 1'b1 : (ps > 0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (data_req) req_n++;
      if (stall_req) stall_n++;
      else k++;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (cyc > 80) begin
        n_cmp++; n_bad++;
        $display("FAIL access_timeout: stall_req still %0b after %0d cycles", stall_req, cyc);
        mem_en = 1'b0; pipe_stall = 1'b0; fin = 1'b1;
      end else if (k == 0) begin
        if (fl == 1 && cyc == 2 + ad) begin
          flush = 1'b1;
          mem_en = 1'b0;
        end
      end else if (!mem_en) begin
        fin = 1'b1;
      end else if (fl == 2) begin
        if (k == 1) begin
          flush = 1'b1;
        end else begin
          void'(rd_q.pop_front());
          mem_en = 1'b0; pipe_stall = 1'b0; fin = 1'b1;
        end
      end else if (k <= ps) begin
        pipe_stall = (k + 1 <= ps);
      end else begin
        mem_en = 1'b0; pipe_stall = 1'b0; fin = 1'b1;
      end
    end
    chk("stall_cycles", 32'(stall_n), 32'(3 + ad + dd));
    chk("req_cycles",   32'(req_n),   32'(1 + ad));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    pipe_stall = 1'b0; flush = 1'b0;
    model_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // zero-wait word load
    access(1'b0, SIZE_WORD, 32'h8000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    // byte store, addr_ok three cycles late; read bus garbage must not be kept
    access(1'b1, SIZE_BYTE, 32'h8000_0003, 32'h4400_0000, 3, 0, 32'hBAD0_0001, 0, 0);
    // load held in DONE by pipe_stall for two cycles
    access(1'b0, SIZE_HALF, 32'h8000_0020, 32'h0, 1, 1, 32'hCAFE_F00D, 2, 0);
    // flush in WAIT, data_ok two cycles later, then a fresh load
    access(1'b0, SIZE_WORD, 32'h8000_0030, 32'h0, 0, 2, 32'h1234_5678, 0, 1);
    access(1'b0, SIZE_WORD, 32'h8000_0034, 32'h0, 0, 0, 32'h0BAD_F00D, 0, 0);

    // flushed instruction in IDLE: no stall, no request
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h8000_0100; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    mem_en = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // flush while frozen in DONE
    access(1'b0, SIZE_WORD, 32'h8000_0040, 32'h0, 1, 0, 32'h5555_AAAA, 0, 2);
    access(1'b1, SIZE_HALF, 32'h8000_0042, 32'h0000_77EE, 0, 1, 32'h0, 0, 0);

    // reset while the request is waiting for addr_ok
    cfg_a_dly = 6; cfg_d_dly = 0; cfg_rdata = 32'h0;
    req_q.push_back('{wr: 1'b0, size: SIZE_WORD, addr: 32'h8000_0200, wdata: 32'h0});
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = SIZE_WORD; mem_addr = 32'h8000_0200; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_en = 1'b0;
    #1;
    chk_reset("midreq");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = '0;
    @(posedge clk);
    #1;
    access(1'b0, SIZE_WORD, 32'h8000_0204, 32'h0, 1, 0, 32'hFEED_0001, 0, 0);

    // randomized accesses with stray data_ok pulses
    spurious_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r, fl;
      r  = int'($urandom_range(7, 0));
      fl = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      access(1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), $urandom, $urandom,
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom,
             int'($urandom_range(2, 0)), fl);
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    spurious_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("rd_q_drained",  32'(rd_q.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_data_sram_bridge
